video_palette: RTL and testbench

- Palette lookup stage directly upstream of the VGA output stage.
- Converts the composer's 8-bit pixel index into the 12-bit RGB value on palette_rgb_data, with a fixed 2-cycle latency. This matches the output stage's internal 2-stage sync/active delay.
- Holds a 256-entry × 12-bit palette, byte-addressable from the CPU bus as 512 bytes, with registered read-back.
- Optionally fills itself with a default greyscale ramp after reset.

---
 rtl/video_palette_pkg.sv | 22 ++
 rtl/palette_dpram.sv | 33 +++
 rtl/video_palette.sv | 116 +++++++++++
 tb/tb_video_palette.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_palette_pkg.sv
// Shared constants and types for the palette lookup stage (index width, byte lanes,
// init sweep state encoding).
package video_palette_pkg;
   localparam int   PAL_IDX_W   = 8;
   localparam int   RGB_W       = 12;
   localparam logic PAL_BYTE_GB = 1'b0;
   localparam logic PAL_BYTE_R  = 1'b1;

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} init_state_t;

   // One write to the palette: either lane (or both, during the sweep) for one entry.
   typedef struct packed {
      logic                 we_gb;
      logic                 we_r;
      logic [PAL_IDX_W-1:0] idx;
      logic [7:0]           data;
   } pal_wr_t;

   function automatic logic [3:0] grey_level(input logic [PAL_IDX_W-1:0] idx);
      return idx[7:4];
   endfunction
endpackage

// File: rtl/palette_dpram.sv
// Simple dual-port RAM: port a is read-only, port b is read/write; both reads are
// registered and read-before-write. Contents are never reset.
module palette_dpram #(
   parameter int DW    = 8,
   parameter int AW    = 8,
   parameter int DEPTH = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_en,
   input  logic          a_clr,
   input  logic [AW-1:0] a_addr,
   output logic [DW-1:0] a_rdata,
   input  logic          b_en,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic [DW-1:0] b_rdata
);
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk)
      if (b_we) mem[b_addr] <= b_wdata;

   always_ff @(posedge clk or posedge rst)
      if (rst)        a_rdata <= '0;
      else if (a_clr) a_rdata <= '0;
      else if (a_en)  a_rdata <= mem[a_addr];

   always_ff @(posedge clk or posedge rst)
      if (rst)       b_rdata <= '0;
      else if (b_en) b_rdata <= mem[b_addr];
endmodule

// File: rtl/video_palette.sv
// Palette lookup: 8-bit pixel index -> 12-bit RGB with 2-cycle latency, CPU byte access.
// Define PALETTE_INIT_EN to fill a greyscale ramp after every reset.
module video_palette #(
   parameter int PAL_ENTRIES = 256,
   parameter int RGB_W       = 12
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    next_pixel,
   input  logic [video_palette_pkg::PAL_IDX_W-1:0] pixel_index,
   output logic [RGB_W-1:0]                        palette_rgb_data,
   input  logic [video_palette_pkg::PAL_IDX_W:0]   bus_addr,
   input  logic [7:0]                              bus_wrdata,
   input  logic                                    bus_write,
   input  logic                                    bus_read,
   output logic [7:0]                              bus_rddata,
   output logic                                    bus_rdvalid,
   output logic                                    init_busy
);
   import video_palette_pkg::*;

   logic [PAL_IDX_W-1:0] idx_q, init_idx;
   logic                 init_we;
   pal_wr_t              wr;
   logic [7:0]           lo_vid, lo_bus;
   logic [3:0]           hi_vid, hi_bus;
   logic                 rd_vld, rd_odd, rd_zero;

`ifdef PALETTE_INIT_EN
   init_state_t          state_q, state_d;
   logic [PAL_IDX_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      init_we = 1'b0;
      case (state_q)
         INIT: begin
            init_we = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == PAL_IDX_W'(PAL_ENTRIES - 1)) state_d = RUN;
         end
         default: ;
      endcase
   end

   assign init_busy = (state_q == INIT);
   assign init_idx  = cnt_q;
`else
   assign init_busy = 1'b0;
   assign init_we   = 1'b0;
   assign init_idx  = '0;
`endif

   // The sweep owns the write port while busy; bus writes are simply dropped.
   always_comb begin
      wr = '0;
      if (init_busy) begin
         wr.we_gb = init_we;
         wr.we_r  = init_we;
         wr.idx   = init_idx;
         wr.data  = {grey_level(init_idx), grey_level(init_idx)};
      end else begin
         wr.we_gb = bus_write && (bus_addr[0] == PAL_BYTE_GB);
         wr.we_r  = bus_write && (bus_addr[0] == PAL_BYTE_R);
         wr.idx   = bus_addr[PAL_IDX_W:1];
         wr.data  = bus_wrdata;
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst)             idx_q <= '0;
      else if (next_pixel) idx_q <= pixel_index;

   // Stage 2 lives in the RAMs' video read registers; clearing them blanks output while busy.
   palette_dpram #(.DW(8), .AW(PAL_IDX_W), .DEPTH(PAL_ENTRIES)) u_lo_ram (
      .clk(clk), .rst(rst),
      .a_en(next_pixel), .a_clr(init_busy), .a_addr(idx_q), .a_rdata(lo_vid),
      .b_en(bus_read), .b_we(wr.we_gb), .b_addr(wr.idx), .b_wdata(wr.data), .b_rdata(lo_bus)
   );

   palette_dpram #(.DW(4), .AW(PAL_IDX_W), .DEPTH(PAL_ENTRIES)) u_hi_ram (
      .clk(clk), .rst(rst),
      .a_en(next_pixel), .a_clr(init_busy), .a_addr(idx_q), .a_rdata(hi_vid),
      .b_en(bus_read), .b_we(wr.we_r), .b_addr(wr.idx), .b_wdata(wr.data[3:0]), .b_rdata(hi_bus)
   );

   assign palette_rgb_data = {hi_vid, lo_vid};

   // Lane select and busy state travel with the read so the data holds until the next read.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_vld  <= 1'b0;
         rd_odd  <= 1'b0;
         rd_zero <= 1'b0;
      end else begin
         rd_vld <= bus_read;
         if (bus_read) begin
            rd_odd  <= bus_addr[0];
            rd_zero <= init_busy;
         end
      end

   assign bus_rdvalid = rd_vld;
   assign bus_rddata  = rd_zero                ? 8'h00 :
                        (rd_odd == PAL_BYTE_R) ? {4'h0, hi_bus} : lo_bus;
endmodule

// File: tb/tb_video_palette.sv
// Scoreboard bench for video_palette: random and directed traffic against a palette model.
module tb_video_palette;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        next_pixel;
   logic [7:0]  pixel_index;
   logic [11:0] palette_rgb_data;
   logic [8:0]  bus_addr;
   logic [7:0]  bus_wrdata;
   logic        bus_write, bus_read;
   logic [7:0]  bus_rddata;
   logic        bus_rdvalid, init_busy;

   video_palette dut (
      .clk(clk), .rst(rst), .next_pixel(next_pixel), .pixel_index(pixel_index),
      .palette_rgb_data(palette_rgb_data), .bus_addr(bus_addr), .bus_wrdata(bus_wrdata),
      .bus_write(bus_write), .bus_read(bus_read), .bus_rddata(bus_rddata),
      .bus_rdvalid(bus_rdvalid), .init_busy(init_busy)
   );

   always #5 clk = ~clk;

`ifdef PALETTE_INIT_EN
   localparam bit INIT_EN = 1'b1;
`else
   localparam bit INIT_EN = 1'b0;
`endif

   typedef struct { logic [11:0] val; bit known; } vexp_t;
   typedef struct { logic [7:0] val; bit known; int due; } rexp_t;

   int          checks = 0, errors = 0;
   logic [11:0] pal [256];
   bit          kn_gb [256];
   bit          kn_r  [256];
   vexp_t       vq[$];
   rexp_t       rq[$];
   vexp_t       v_last;
   rexp_t       r_last;
   logic [7:0]  prev_idx;
   int          since_rst = 0;
   int          edge_cnt = 0;
   bit          adv = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      edge_cnt <= edge_cnt + 1;
      adv      <= next_pixel && !rst;
   end

   // Monitor: pops an expectation whenever the DUT advances video or pulses read-valid.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         check("init_busy", 32'(init_busy), 32'(INIT_EN && since_rst < 256));
         if (adv) begin
            if (vq.size() == 0) begin
               checks++; errors++;
               $display("FAIL video_queue: advance seen, expected none pending (t=%0t)", $time);
            end else v_last = vq.pop_front();
         end
         if (v_last.known) check(adv ? "video" : "video_hold", 32'(palette_rgb_data), 32'(v_last.val));
         if (bus_rdvalid) begin
            if (rq.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_queue: rdvalid seen, expected no read pending (t=%0t)", $time);
            end else begin
               r_last = rq.pop_front();
               check("rd_latency", 32'(edge_cnt), 32'(r_last.due));
            end
         end
         if (r_last.known) check(bus_rdvalid ? "rd_data" : "rd_hold", 32'(bus_rddata), 32'(r_last.val));
      end
   end

   task automatic idle();
      next_pixel = 1'b0; pixel_index = '0; bus_addr = '0;
      bus_wrdata = '0;   bus_write = 1'b0; bus_read = 1'b0;
   endtask

   // Drive one clock's inputs and record what the palette rules say must come out.
   task automatic cyc(input bit np, input logic [7:0] idx, input bit wr, input bit rd,
                      input logic [8:0] addr, input logic [7:0] wd);
      bit busy;
      vexp_t v;
      rexp_t r;
      logic [7:0] e;
      @(negedge clk); #2;
      next_pixel = np; pixel_index = idx; bus_write = wr; bus_read = rd;
      bus_addr = addr; bus_wrdata = wd;
      busy = INIT_EN && since_rst < 256;
      e = addr[8:1];
      if (np) begin
         v.val   = busy ? 12'h000 : pal[prev_idx];
         v.known = busy || (kn_gb[prev_idx] && kn_r[prev_idx]);
         vq.push_back(v);
         prev_idx = idx;
      end
      if (rd) begin
         r.due = edge_cnt + 1;
         if (busy)         begin r.val = 8'h00;                r.known = 1'b1;     end
         else if (addr[0]) begin r.val = {4'h0, pal[e][11:8]}; r.known = kn_r[e];  end
         else              begin r.val = pal[e][7:0];          r.known = kn_gb[e]; end
         rq.push_back(r);
      end
      if (wr && !busy) begin
         if (addr[0]) begin pal[e][11:8] = wd[3:0]; kn_r[e]  = 1'b1; end
         else         begin pal[e][7:0]  = wd;      kn_gb[e] = 1'b1; end
      end
      since_rst++;
   endtask

   task automatic do_reset(input int hold);
      @(negedge clk); #2;
      rst = 1'b1;
      idle();
      vq.delete(); rq.delete();
      prev_idx = '0;
      v_last = '{12'h000, 1'b1};
      r_last = '{8'h00, 1'b1, 0};
      repeat (hold) @(negedge clk);
      #1;
      check("rst_rgb",     32'(palette_rgb_data), 32'h0);
      check("rst_rddata",  32'(bus_rddata),       32'h0);
      check("rst_rdvalid", 32'(bus_rdvalid),      32'h0);
      check("rst_busy",    32'(init_busy),        32'(INIT_EN));
      if (INIT_EN)
         for (int i = 0; i < 256; i++) begin
            pal[i] = {3{4'(i >> 4)}}; kn_gb[i] = 1'b1; kn_r[i] = 1'b1;
         end
      #1;
      rst = 1'b0;
      since_rst = 1;
   endtask

   task automatic peek_rgb(input string name, input logic [11:0] exp);
      @(posedge clk); #1;
      check(name, 32'(palette_rgb_data), 32'(exp));
   endtask

   task automatic peek_rd(input string name, input logic [7:0] exp);
      @(posedge clk); #1;
      check({name, "_valid"}, 32'(bus_rdvalid), 32'h1);
      check(name, 32'(bus_rddata), 32'(exp));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] ix;
      logic [8:0] ad;
      idle();
      for (int i = 0; i < 256; i++) begin pal[i] = '0; kn_gb[i] = 1'b0; kn_r[i] = 1'b0; end
      do_reset(3);

`ifdef PALETTE_INIT_EN
      // Bus traffic during the sweep: writes must vanish, reads return zero.
      for (int i = 0; i < 255; i++)
         cyc(1'b1, 8'($urandom), 1'b1, $urandom_range(0, 1) == 1, 9'($urandom), 8'($urandom));
      cyc(1'b1, 8'h37, 1'b0, 1'b0, '0, '0);
      cyc(1'b1, 8'hF0, 1'b0, 1'b0, '0, '0);
      peek_rgb("init_idx37", 12'h333);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, '0, '0);
      peek_rgb("init_idxF0", 12'hFFF);
      for (int i = 0; i < 256; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, '0, '0);
      // Reset when the sweep is at entry 100, then let it run to completion.
      do_reset(2);
      repeat (99) cyc(1'b1, 8'($urandom), $urandom_range(0, 1) == 1, 1'b0, 9'($urandom), 8'($urandom));
      do_reset(2);
      repeat (300) cyc(1'b1, 8'($urandom), 1'b0, 1'b0, '0, '0);
`endif

      // Basic lookup: entry 0x0A = {R=C, G=A, B=B}.
      cyc(1'b0, '0, 1'b1, 1'b0, 9'h014, 8'hAB);
      cyc(1'b0, '0, 1'b1, 1'b0, 9'h015, 8'hFC);
      cyc(1'b0, '0, 1'b1, 1'b0, 9'h006, 8'h5A);
      cyc(1'b0, '0, 1'b1, 1'b0, 9'h007, 8'h07);
      cyc(1'b1, 8'h0A, 1'b0, 1'b0, '0, '0);
      cyc(1'b1, 8'h03, 1'b0, 1'b0, '0, '0);
      peek_rgb("lookup_0A", 12'hCAB);
      // Freeze for three cycles with a changing index, then resume.
      cyc(1'b0, 8'($urandom), 1'b0, 1'b0, '0, '0);
      cyc(1'b0, 8'($urandom), 1'b0, 1'b0, '0, '0);
      cyc(1'b0, 8'($urandom), 1'b0, 1'b0, '0, '0);
      peek_rgb("freeze_hold", 12'hCAB);
      cyc(1'b1, 8'h0A, 1'b0, 1'b0, '0, '0);
      peek_rgb("resume_first", 12'h75A);
      cyc(1'b1, 8'h0A, 1'b1, 1'b0, 9'h014, 8'h12);
      peek_rgb("same_cycle_old", 12'hCAB);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, '0, '0);
      peek_rgb("next_sample_new", 12'hC12);

      // Bus read-back.
      cyc(1'b0, '0, 1'b0, 1'b1, 9'h015, '0);
      peek_rd("rd_odd_015", 8'h0C);
      cyc(1'b0, '0, 1'b1, 1'b1, 9'h014, 8'h99);
      peek_rd("rd_wr_same_addr", 8'h12);
      cyc(1'b0, '0, 1'b1, 1'b0, 9'h015, 8'hF3);
      cyc(1'b0, '0, 1'b0, 1'b1, 9'h015, '0);
      peek_rd("rd_odd_upper_ignored", 8'h03);
      cyc(1'b0, '0, 1'b0, 1'b1, 9'h014, '0);
      peek_rd("rd_even_after_wr", 8'h99);

      // Fill every byte, then mixed random traffic concentrated on a few entries.
      for (int a = 0; a < 512; a++)
         cyc($urandom_range(0, 1) == 1, 8'($urandom), 1'b1, $urandom_range(0, 3) == 0, 9'(a), 8'($urandom));
      for (int i = 0; i < 1500; i++) begin
         ix = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
         ad = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
         cyc($urandom_range(0, 3) != 0, ix, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0, ad, 8'($urandom));
      end
      repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, '0, '0);
      @(negedge clk); #1;
      check("rd_queue_drained", 32'(rq.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
